// File: rtl/q_pkg.sv
// Shared fixed-point constants and the saturating shift helper for the
// Q-learning update pipeline.
package q_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Arithmetic (floor) shift right, then clamp to a dw-bit signed range.
  function automatic wide_t sat_shift(input wide_t x, input int shift, input int dw);
    wide_t y;
    wide_t hi;
    wide_t lo;
    y  = x >>> shift;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    if (y > hi) return hi;
    if (y < lo) return lo;
    return y;
  endfunction

endpackage

// File: rtl/q_max_tree.sv
// Combinational signed max/argmax over a packed vector; the lowest index
// wins on ties because only a strictly greater entry replaces the running max.
module q_max_tree
  import q_pkg::*;
#(
  parameter int N_ACT = 9,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic [N_ACT*DW-1:0] vals_i,
  output logic [DW-1:0]       max_o,
  output logic [AW-1:0]       idx_o
);

  always_comb begin
    max_o = vals_i[DW-1:0];
    idx_o = '0;
    for (int i = 1; i < N_ACT; i++) begin
      if ($signed(vals_i[i*DW +: DW]) > $signed(max_o)) begin
        max_o = vals_i[i*DW +: DW];
        idx_o = AW'(i);
      end
    end
  end

endmodule

// File: rtl/q_learning_pipe.sv
// Four-stage Q-learning update: q_new = Q + alpha*(reward + gamma*maxQ' - Q),
// with a single global advance so the whole pipe stalls together.
module q_learning_pipe
  import q_pkg::*;
#(
  parameter int N_ACT = 9,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       action,
  input  logic [N_ACT*DW-1:0] q_cur,
  input  logic [N_ACT*DW-1:0] q_next,
  input  logic [DW-1:0]       reward,
  input  logic [DW-1:0]       alpha,
  input  logic [DW-1:0]       gamma,
  input  logic                terminal,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       q_new,
  output logic [AW-1:0]       best_act,
  output logic                out_err,
  output logic [31:0]         upd_count
);

  function automatic wide_t sx(input logic [DW-1:0] a);
    return wide_t'(signed'(a));
  endfunction

  function automatic logic [DW-1:0] sat_dw(input wide_t x, input int sh);
    return DW'(sat_shift(x, sh, DW));
  endfunction

  // Unsigned coefficient times signed operand, full precision, then floor-shift.
  function automatic logic [DW-1:0] mul_frac(input logic [DW-1:0] u, input logic [DW-1:0] s);
    logic signed [2*DW:0] a;
    logic signed [2*DW:0] b;
    a = $signed((2*DW+1)'({1'b0, u}));
    b = (2*DW+1)'(signed'(s));
    return sat_dw(wide_t'(a * b), FRAC);
  endfunction

  logic adv;
  logic [DW-1:0] q_sel_d;
  logic err_d;
  logic [DW-1:0] max_d, boot_d, tgt_d, td_d, q_new_d;
  logic [AW-1:0] best_d;

  logic s1_v_q, s1_err_q, s1_term_q;
  logic [DW-1:0] s1_qs_q, s1_rew_q, s1_alpha_q, s1_gamma_q;
  logic [N_ACT*DW-1:0] s1_qn_q;

  logic s2_v_q, s2_err_q, s2_term_q;
  logic [DW-1:0] s2_qs_q, s2_max_q, s2_rew_q, s2_alpha_q, s2_gamma_q;
  logic [AW-1:0] s2_best_q;

  logic s3_v_q, s3_err_q;
  logic [DW-1:0] s3_qs_q, s3_td_q, s3_alpha_q;
  logic [AW-1:0] s3_best_q;

  logic out_valid_q, out_err_q;
  logic [DW-1:0] q_new_q;
  logic [AW-1:0] best_act_q;
  logic [31:0] upd_count_q;

  assign adv      = out_ready || !out_valid_q;
  assign in_ready = adv && reset_n;

  always_comb begin
    q_sel_d = '0;
    for (int i = 0; i < N_ACT; i++) begin
      if (action == AW'(i)) q_sel_d = q_cur[i*DW +: DW];
    end
  end
  assign err_d = ({1'b0, action} >= (AW+1)'(N_ACT));

  q_max_tree #(.N_ACT(N_ACT), .DW(DW), .AW(AW)) u_max (
    .vals_i (s1_qn_q),
    .max_o  (max_d),
    .idx_o  (best_d)
  );

  assign boot_d  = s2_term_q ? '0 : mul_frac(s2_gamma_q, s2_max_q);
  assign tgt_d   = sat_dw(sx(s2_rew_q) + sx(boot_d), 0);
  assign td_d    = sat_dw(sx(tgt_d) - sx(s2_qs_q), 0);
  assign q_new_d = s3_err_q ? '0 : sat_dw(sx(s3_qs_q) + sx(mul_frac(s3_alpha_q, s3_td_q)), 0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v_q <= 1'b0; s1_err_q <= 1'b0; s1_term_q <= 1'b0;
      s1_qs_q <= '0; s1_rew_q <= '0; s1_alpha_q <= '0; s1_gamma_q <= '0; s1_qn_q <= '0;
      s2_v_q <= 1'b0; s2_err_q <= 1'b0; s2_term_q <= 1'b0;
      s2_qs_q <= '0; s2_max_q <= '0; s2_rew_q <= '0; s2_alpha_q <= '0; s2_gamma_q <= '0;
      s2_best_q <= '0;
      s3_v_q <= 1'b0; s3_err_q <= 1'b0;
      s3_qs_q <= '0; s3_td_q <= '0; s3_alpha_q <= '0; s3_best_q <= '0;
      out_valid_q <= 1'b0; out_err_q <= 1'b0; q_new_q <= '0; best_act_q <= '0;
      upd_count_q <= '0;
    end else begin
      if (adv) begin
        s1_v_q     <= in_valid;
        s1_err_q   <= err_d;
        s1_term_q  <= terminal;
        s1_qs_q    <= q_sel_d;
        s1_rew_q   <= reward;
        s1_alpha_q <= alpha;
        s1_gamma_q <= gamma;
        s1_qn_q    <= q_next;

        s2_v_q     <= s1_v_q;
        s2_err_q   <= s1_err_q;
        s2_term_q  <= s1_term_q;
        s2_qs_q    <= s1_qs_q;
        s2_max_q   <= max_d;
        s2_best_q  <= best_d;
        s2_rew_q   <= s1_rew_q;
        s2_alpha_q <= s1_alpha_q;
        s2_gamma_q <= s1_gamma_q;

        s3_v_q     <= s2_v_q;
        s3_err_q   <= s2_err_q;
        s3_qs_q    <= s2_qs_q;
        s3_td_q    <= td_d;
        s3_best_q  <= s2_best_q;
        s3_alpha_q <= s2_alpha_q;

        out_valid_q <= s3_v_q;
        out_err_q   <= s3_err_q;
        q_new_q     <= q_new_d;
        best_act_q  <= s3_best_q;
      end
      if (out_valid_q && out_ready && !out_err_q) upd_count_q <= upd_count_q + 32'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign q_new     = q_new_q;
  assign best_act  = best_act_q;
  assign upd_count = upd_count_q;

endmodule

// File: doc/q_learning_pipe.md
Q_LEARNING_PIPE -- requirements
Module: q_learning_pipe

Interface
REQ-001 Parameter N_ACT, default 9: number of actions and Q-values per state vector (2..16).
REQ-002 Parameter DW, default 16: signed fixed-point width of Q, reward, alpha and gamma.
REQ-003 Parameter FRAC, default 8: fraction bits of every fixed-point operand (Q8.8 at defaults).
REQ-004 Parameter AW, default 4: action index width; 2^AW >= N_ACT.
REQ-005 clock  in  1  single rising-edge clock.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 in_valid  in  1  input transaction present.
REQ-008 in_ready  out  1  block accepts transaction this cycle.
REQ-009 action  in  AW  index of the action taken.
REQ-010 q_cur  in  N_ACT*DW  Q(s,·); entry i at bits [i*DW +: DW].
REQ-011 q_next  in  N_ACT*DW  Q(s',·), packed the same way.
REQ-012 reward  in  DW  signed immediate reward.
REQ-013 alpha  in  DW  learning rate, unsigned, sampled with the transaction.
REQ-014 gamma  in  DW  discount factor, unsigned, sampled with the transaction.
REQ-015 terminal  in  1  s' is terminal; bootstrap term is forced to 0.
REQ-016 out_valid  out  1  result present.
REQ-017 out_ready  in  1  consumer accepts result.
REQ-018 q_new  out  DW  updated Q(s,action).
REQ-019 best_act  out  AW  argmax index of q_next.
REQ-020 out_err  out  1  action >= N_ACT.
REQ-021 upd_count  out  32  number of error-free results accepted by the consumer.

Function
REQ-022 Computes q_new = Q + alpha*(reward + gamma*maxQ' - Q), Q = q_cur[action], maxQ' = max over q_next.
REQ-023 Four-stage pipeline: S1 capture and select Q; S2 max/argmax; S3 target and TD error; S4 alpha product and sum.
REQ-024 Latency: exactly 4 cycles from in_valid&&in_ready to out_valid, with out_ready held high.
REQ-025 Throughput: one transaction per cycle while out_ready is high.
REQ-026 Global advance = out_ready || !out_valid; in_ready = advance; no stage moves while advance is low.
REQ-027 Bubbles propagate as per-stage valid bits; results leave in acceptance order, none dropped or duplicated.
REQ-028 Outputs hold stable while out_valid && !out_ready.
REQ-029 Max: signed compare; on a tie, the lowest index wins for both value and best_act.
REQ-030 Products: full 2*DW signed product, arithmetic shift right by FRAC (floor), then saturate.
REQ-031 Every add, subtract and product result saturates to [-2^(DW-1), 2^(DW-1)-1]; no wrap.
REQ-032 terminal=1: gamma*maxQ' term = 0; best_act still reports the argmax.
REQ-033 action >= N_ACT: out_err=1, q_new=0; upd_count unchanged.
REQ-034 upd_count increments on out_valid&&out_ready&&!out_err; wraps from 2^32-1 to 0.

Reset
REQ-035 Sampled at the clock edge while reset_n=0: all stage valids, out_valid, q_new, best_act, out_err and upd_count clear to 0.
REQ-036 During reset, in_ready=0.
REQ-037 Reset mid-operation discards all in-flight transactions; no result appears after deassertion without new input.

Structure
REQ-038 Shared package q_pkg holds the saturation width constants and a sat/shift helper function used by S3 and S4.
REQ-039 One sub-module, q_max_tree: combinational signed max/argmax over N_ACT entries, lowest-index tie-break.

Verification
All values are Q8.8 at default parameters.
REQ-040 Nominal update: Q=0x0100, maxQ'=0x0200, reward=0x0100, alpha=0x0080, gamma=0x00E6 -> q_new=0x01E6 after 4 cycles.
REQ-041 Terminal: same stimulus with terminal=1 -> q_new=0x0100.
REQ-042 Saturation: Q=0x7F00, reward=0x7FFF, maxQ'=0x7FFF, alpha=0x0100 -> q_new=0x7FFF, no wrap.
REQ-043 Back-pressure: 6 back-to-back transactions with out_ready low for 3 cycles mid-stream -> all 6 results in order, in_ready low while stalled.
REQ-044 Invalid action and tie: action=9 -> out_err=1, q_new=0, upd_count unchanged; q_next entries 2 and 5 both 0x0300 and maximal -> best_act=2.
REQ-045 Reset mid-stream: reset_n=0 for one cycle with 3 transactions in flight -> out_valid=0 and upd_count=0 next cycle, no stale output afterwards.
